// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - four-sample frame sequencer around an FFT core
// Optional done-watchdog enabled by defining FFT_CTRL_TIMEOUT_EN.
module fft_frame_ctrl #(
    parameter int WIDTH   = 36,
    parameter int TMO_CYC = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   fft_f,
    output logic                 fft_start,
    output logic                 fft_reset,
    input  logic [4*WIDTH-1:0]   fft_F,
    input  logic                 fft_done,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          frame_count
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t           state;
    logic [1:0]       idx;
    logic [WIDTH-1:0] buf_q [4];
    logic             timeout_hit;

`ifdef FFT_CTRL_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Counts WAIT cycles; zeroed while in START so the first WAIT cycle sees 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == S_START) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == S_WAIT) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (timeout_hit && !fft_done) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = ^TMO_LAST;
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_LOAD;
            idx         <= 2'd0;
            in_ready    <= 1'b1;
            fft_start   <= 1'b0;
            fft_reset   <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            fft_f       <= '0;
            frame_count <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    fft_reset <= 1'b0;
                    if (in_valid) begin
                        fft_f[int'(idx)*WIDTH +: WIDTH] <= in_data;
                        if (idx == 2'd3) begin
                            idx       <= 2'd0;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                            fft_start <= 1'b1;
                            state     <= S_START;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                S_START: begin
                    fft_start <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the watchdog's last cycle still wins.
                    if (fft_done) begin
                        for (int i = 0; i < 4; i++) begin
                            buf_q[i] <= fft_F[i*WIDTH +: WIDTH];
                        end
                        out_data  <= fft_F[WIDTH-1:0];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        idx       <= 2'd0;
                        state     <= S_DRAIN;
                    end else if (timeout_hit) begin
                        fft_reset <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (idx == 2'd3) begin
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            frame_count <= frame_count + 16'd1;
                            fft_reset   <= 1'b1;
                            idx         <= 2'd0;
                            state       <= S_CLEAR;
                        end else begin
                            idx      <= idx + 2'd1;
                            out_data <= buf_q[idx + 2'd1];
                            out_last <= (idx == 2'd2);
                        end
                    end
                end
                S_CLEAR: begin
                    fft_reset <= 1'b0;
                    idx       <= 2'd0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_LOAD;
                end
                default: begin
                    fft_start <= 1'b0;
                    fft_reset <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    idx       <= 2'd0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 36, the packed complex sample width (upper half real, lower half imaginary, two's complement).
REQ-002 SHALL have parameter TMO_CYC, default 255, the done-watchdog limit in cycles (used only with FFT_CTRL_TIMEOUT_EN).
REQ-003 SHALL use one clock and an asynchronous active-low reset, as already decided.
REQ-004 SHALL have these ports, one per line as name, direction, width, meaning:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- in_data  in  WIDTH  input sample
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts a sample
- fft_f  out  4xWIDTH  frame to core, held stable START..WAIT
- fft_start  out  1  one-cycle start pulse to core
- fft_reset  out  1  active-high core return-to-idle
- fft_F  in  4xWIDTH  core results
- fft_done  in  1  core results valid
- out_data  out  WIDTH  result sample
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts a result
- out_last  out  1  marks result index 3
- busy  out  1  high when state is not LOAD
- err  out  1  sticky watchdog error
- frame_count  out  16  completed frames

Function
REQ-005 SHALL implement the states LOAD, START, WAIT, DRAIN and CLEAR, held in a 3-bit register with a 2-bit index idx.
REQ-006 LOAD: in_ready=1; each in_valid&in_ready cycle SHALL write fft_f[idx] and increment idx; after accepting idx=3 SHALL go to START with idx=0.
REQ-007 START: SHALL drive fft_start=1 for exactly one cycle, then go to WAIT.
REQ-008 WAIT: on fft_done=1 SHALL copy fft_F[0..3] into the output buffer the same edge and go to DRAIN; SHALL make no assumption about core latency (the nominal value is 3 cycles after fft_start).
REQ-009 DRAIN: SHALL drive out_valid=1 with out_data=buf[idx], and out_last=1 when idx=3.
REQ-010 In DRAIN, on out_valid&out_ready SHALL increment idx; on the last handshake SHALL increment frame_count and go to CLEAR.
REQ-011 CLEAR: SHALL drive fft_reset=1 for exactly one cycle, then go to LOAD with idx=0.
REQ-012 While out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-013 in_ready SHALL be 0 outside LOAD, and in_valid SHALL be ignored there; no sample is lost, because the source must hold in_valid until accepted.
REQ-014 fft_done SHALL be ignored outside WAIT.
REQ-015 fft_f SHALL be unchanged from the START entry until CLEAR exit.
REQ-016 frame_count SHALL wrap from 0xFFFF to 0x0000.
REQ-017 Data SHALL pass through the controller unmodified; it performs no arithmetic.

Reset
REQ-018 While reset=0: state=LOAD, idx=0, in_ready=1, out_valid=0, out_last=0, fft_start=0, fft_reset=1, busy=0, err=0, frame_count=0, and fft_f and the output buffer are zero.
REQ-019 Reset asserted mid-frame SHALL discard any partial input frame or undrained results; the first cycle after release is LOAD.

Configuration
REQ-020 With FFT_CTRL_TIMEOUT_EN defined, an 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-021 With FFT_CTRL_TIMEOUT_EN defined, reaching TMO_CYC without fft_done SHALL set err (sticky until reset), drop the frame without incrementing frame_count, and go to CLEAR; fft_done arriving in that same cycle SHALL take priority.
REQ-022 With FFT_CTRL_TIMEOUT_EN undefined, there SHALL be no counter, WAIT SHALL persist indefinitely, and err SHALL be tied to 0.

Verification
REQ-023 The bench SHALL cover: samples 1,2,3,4 with in_valid continuous, out_ready=1, and a core model with done at +3 cycles -> one fft_start pulse, outputs [10,-2+2j,-2,-2-2j] in order, out_last on the 4th, frame_count=1, one fft_reset pulse.
REQ-024 The bench SHALL cover: out_ready toggling 1-0-0-1 during DRAIN -> out_data stable while stalled, exactly 4 handshakes, and in_ready=0 throughout.
REQ-025 The bench SHALL cover: in_valid asserted during WAIT and DRAIN -> no write to fft_f, and the next frame begins with that held sample as index 0.
REQ-026 The bench SHALL cover: reset pulsed low after 2 accepted samples -> all outputs at reset values, and the next 4 samples form a fresh frame.
REQ-027 The bench SHALL cover, with FFT_CTRL_TIMEOUT_EN: fft_done never asserted -> err=1 after 255 WAIT cycles, fft_reset pulses, frame_count unchanged, and the next frame completes normally with err still 1.
REQ-028 The bench SHALL cover: 65536 frames -> frame_count returns to 0.
